bitcell_array_responder: RTL and testbench
==========================================

// Module: bitcell_array_responder
// PURPOSE
//  Memory-side responder for the bitcell controller FSM's valid/rw request interface.
//  Holds a DEPTH x WIDTH array of storage cells.
//  Accepts one request at a time and models a multi-cycle write and a single-cycle
//  sensed read. Completes each request with a four-phase valid/ack handshake.
//  Sits between the controller FSM and the NAND-latch bitcell storage.
// PARAMETERS
//  WIDTH   8  data bits per word
//  DEPTH   4  number of words; non-power-of-2 allowed
//  ADDR_W  2  address width; 2**ADDR_W >= DEPTH
//  WR_LAT  2  cycles from accept to write commit; legal range 1..15
// PORTS
//  clk    in   1       rising-edge clock, the only clock
//  rst    in   1       synchronous reset, active-high
//  valid  in   1       request strobe from controller; held high until ack seen
//  rw     in   1       1 = write, 0 = read; sampled with valid
//  addr   in   ADDR_W  word address; sampled with valid
//  wdata  in   WIDTH   write data; sampled with valid
//  rdata  out  WIDTH   read data; valid while ack=1, held until next read completes
//  ack    out  1       request complete; registered
//  busy   out  1       1 in any state other than IDLE; registered
//  err    out  1       address >= DEPTH; qualified by ack
// BEHAVIOUR
//  Reset (rst=1 at clk edge)
//   - state<=IDLE; ack, busy, err, rdata <= 0; all memory words <= 0; counter <= 0.
//   - rst wins over every other event.
//   - rst during WRITE before the commit edge: the write is discarded.
//  States: IDLE, WRITE, READ, ACK. Encoding is free; registered outputs are decoded from state.
//  IDLE
//   - valid=0: stay in IDLE.
//   - valid=1 at edge k: latch rw, addr, wdata; busy=1 after edge k.
//   - Next state is WRITE if rw=1, else READ.
//  WRITE
//   - Counter runs 0..WR_LAT-1, incrementing each edge.
//   - On the edge where counter==WR_LAT-1: mem[addr_q] <= wdata_q (only if addr_q < DEPTH); go to ACK.
//   - ack=1 after edge k+WR_LAT.
//  READ
//   - Edge k+1: rdata <= mem[addr_q], or 0 if addr_q >= DEPTH; go to ACK.
//   - ack=1 after edge k+1.
//  ACK
//   - ack=1; err=(addr_q >= DEPTH).
//   - Stay in ACK while valid=1.
//   - valid=0: go to IDLE; ack, err, busy = 0 after that edge.
//   - Minimum gap between two accepts: one IDLE cycle.
//  Input handling
//   - addr, wdata and rw changes while busy=1 are ignored; latched copies are used.
//   - valid dropping before ack (protocol violation): the operation still completes,
//     then ACK exits on the next edge.
//  Widths
//   - Address compare is unsigned, ADDR_W bits.
//   - The array is never written with an out-of-range index.
//  Outputs
//   - No combinational path from any input to any output.
//   - rdata keeps its last read value through writes.
// TESTING
//  1 rst=1 for 2 edges, then release -> ack=0, busy=0, err=0, rdata=0; read addr 3 returns 0x00.
//  2 WR_LAT=2: write 0xA5 to addr 2 accepted at edge k
//    -> ack=1 exactly after edge k+2; valid held 3 more cycles -> ack stays 1;
//    valid=0 -> ack=0, busy=0 after next edge.
//  3 Read addr 2 after test 2 -> ack=1 after accept+1, rdata=0xA5, err=0; rdata still 0xA5 after ack drops.
//  4 Write 0x3C to addr 1; change addr to 0 and wdata to 0xFF while busy
//    -> reads return addr1=0x3C, addr0=0x00.
//  5 Write 0x77 to addr 1; assert rst at accept+1 (before commit)
//    -> no ack; after reset, read addr 1 returns 0x00.
//  6 DEPTH=3: write 0x55 to addr 3 -> ack=1, err=1; read addr 3 -> rdata=0x00, err=1;
//    addr 0..2 are unchanged.

Source files
------------

// File: rtl/bitcell_array_responder.sv
// Memory-side responder for the bitcell controller's valid/rw request port.
// Holds a DEPTH x WIDTH array of storage words. It accepts one request at a time.
// A write commits WR_LAT cycles after it is accepted. A read is sensed one cycle
// after it is accepted. Each request finishes with a four-phase valid/ack handshake.
module bitcell_array_responder #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int WR_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic              ack,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_ACK
   } state_t;

   // One extra bit so that DEPTH == 2**ADDR_W is still representable.
   localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      CNT_LAST = 4'(WR_LAT - 1);

   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [WIDTH-1:0]  wdata_reg;
   logic [3:0]        cnt_reg;
   logic [WIDTH-1:0]  mem_reg [DEPTH];

   logic              in_range;
   logic              wr_commit;
   logic [DEPTH-1:0]  word_we;
   logic [WIDTH-1:0]  rd_word;

   assign in_range  = {1'b0, addr_reg} < DEPTH_W;
   assign wr_commit = (state_reg == ST_WRITE) && (cnt_reg == CNT_LAST);

   // There is one write enable per existing word. An out-of-range address
   // therefore matches no word, and nothing is written.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word
         assign word_we[gi] = wr_commit && (addr_reg == ADDR_W'(gi));
      end
   endgenerate

   // Read mux over the existing words. An unmatched address reads as zero.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr_reg == ADDR_W'(i)) rd_word = mem_reg[i];
      end
   end

   // Storage array: cleared by reset, written only on the commit edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (word_we[i]) mem_reg[i] <= wdata_reg;
         end
      end
   end

   // Request FSM with registered handshake outputs and read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
         cnt_reg   <= '0;
         rdata     <= '0;
         ack       <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (valid) begin
                  addr_reg  <= addr;
                  wdata_reg <= wdata;
                  cnt_reg   <= '0;
                  busy      <= 1'b1;
                  state_reg <= rw ? ST_WRITE : ST_READ;
               end
            end
            ST_WRITE: begin
               if (cnt_reg == CNT_LAST) begin
                  cnt_reg   <= '0;
                  ack       <= 1'b1;
                  err       <= ~in_range;
                  state_reg <= ST_ACK;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            ST_READ: begin
               rdata     <= in_range ? rd_word : '0;
               ack       <= 1'b1;
               err       <= ~in_range;
               state_reg <= ST_ACK;
            end
            ST_ACK: begin
               // The ack phase ends only when the controller has released valid.
               if (!valid) begin
                  ack       <= 1'b0;
                  err       <= 1'b0;
                  busy      <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bitcell_array_responder.sv
// Testbench for bitcell_array_responder. It runs directed and random requests
// through a scoreboard. A reference model of the word array predicts each
// response; a monitor compares the predictions when ack rises.
module tb_bitcell_array_responder;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 3;
   localparam int ADDR_W = 2;
   localparam int WR_LAT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  wdata;
   logic [WIDTH-1:0]  rdata;
   logic              ack;
   logic              busy;
   logic              err;

   bitcell_array_responder #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WR_LAT(WR_LAT)
   ) dut (
      .clk(clk), .rst(rst), .valid(valid), .rw(rw), .addr(addr),
      .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] rd;
      logic             er;
      int               lat;
      bit               wr;
      logic [1:0]       a;
   } exp_t;

   exp_t             exp_q[$];
   int               n_cmp = 0;
   int               n_bad = 0;
   logic [WIDTH-1:0] model [4];
   logic [WIDTH-1:0] last_rd;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   // Monitor: time each request from busy rising to ack rising, then check it against the scoreboard.
   initial begin
      logic ack_p = 1'b0;
      logic busy_p = 1'b0;
      int   lat = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy && !busy_p) lat = 0;
         else if (busy) lat++;
         if (ack && !ack_p) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               $display("txn %s addr=%0d rdata=0x%02h err=%0b lat=%0d",
                        e.wr ? "WR" : "RD", e.a, rdata, err, lat);
               chk("rdata", 32'(rdata), 32'(e.rd));
               chk("err", 32'(err), 32'(e.er));
               chk("latency", 32'(lat), 32'(e.lat));
            end
         end
         ack_p  = ack;
         busy_p = busy;
      end
   end

   // Issue one request; the model is updated from the architectural rules.
   task automatic do_req(input bit wr, input logic [1:0] a, input logic [7:0] d,
                         input int hold, input bit corrupt, input logic [1:0] ca,
                         input logic [7:0] cd, input bit early);
      exp_t e;
      bit   got = 0;
      e.wr = wr;
      e.a  = a;
      e.er = (a >= DEPTH);
      if (wr) begin
         if (a < DEPTH) model[a] = d;
         e.rd  = last_rd;
         e.lat = WR_LAT;
      end else begin
         e.rd    = (a < DEPTH) ? model[a] : 8'h00;
         last_rd = e.rd;
         e.lat   = 1;
      end
      exp_q.push_back(e);
      valid = 1'b1;
      rw    = wr;
      addr  = a;
      wdata = d;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (t == 0) begin
            if (corrupt) begin
               addr  = ca;
               wdata = cd;
               rw    = ~wr;
            end
            if (early) valid = 1'b0;
         end
         if (ack) begin
            got = 1;
            break;
         end
      end
      chk("ack_seen", 32'(got), 32'd1);
      if (!early) begin
         repeat (hold) begin
            @(negedge clk);
            chk("ack_hold", 32'(ack), 32'd1);
         end
      end
      valid = 1'b0;
      @(negedge clk);
      chk("ack_drop", 32'(ack), 32'd0);
      chk("busy_drop", 32'(busy), 32'd0);
      chk("err_drop", 32'(err), 32'd0);
      chk("rdata_keep", 32'(rdata), 32'(last_rd));
   endtask

   // Start a write, then reset one edge after the accept, before the commit edge.
   task automatic do_abort(input logic [1:0] a, input logic [7:0] d);
      valid = 1'b1;
      rw    = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd1);
      rst   = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 8'h00;
      last_rd = 8'h00;
      chk("abort_ack", 32'(ack), 32'd0);
      chk("abort_busy_clr", 32'(busy), 32'd0);
      chk("abort_rdata", 32'(rdata), 32'd0);
      $display("txn ABORT addr=%0d", a);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      rw    = 1'b0;
      addr  = '0;
      wdata = '0;
      for (int i = 0; i < 4; i++) model[i] = 8'h00;
      last_rd = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);

      do_req(0, 2'd3, 8'h00, 0, 0, 2'd0, 8'h00, 0);
      do_req(1, 2'd2, 8'hA5, 3, 0, 2'd0, 8'h00, 0);
      do_req(0, 2'd2, 8'h00, 1, 0, 2'd0, 8'h00, 0);
      do_req(1, 2'd1, 8'h3C, 0, 1, 2'd0, 8'hFF, 0);
      do_req(0, 2'd1, 8'h00, 0, 0, 2'd0, 8'h00, 0);
      do_req(0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0);
      do_abort(2'd1, 8'h77);
      do_req(0, 2'd1, 8'h00, 0, 0, 2'd0, 8'h00, 0);
      do_req(1, 2'd0, 8'h11, 0, 0, 2'd0, 8'h00, 0);
      do_req(1, 2'd3, 8'h55, 0, 0, 2'd0, 8'h00, 0);
      do_req(0, 2'd3, 8'h00, 0, 0, 2'd0, 8'h00, 0);
      for (int i = 0; i < DEPTH; i++) do_req(0, 2'(i), 8'h00, 0, 0, 2'd0, 8'h00, 0);

      for (int n = 0; n < 60; n++) begin
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
